seg7_scan_ctrl: RTL and testbench

- Sequencer for the 4-digit multiplexed 7-segment display.
- Time-slices the shared cathode bus across four anodes at a programmable refresh rate.
- Decodes hex nibbles and applies per-digit blanking, decimal points and PWM brightness.
- Double-buffers host writes so they commit only at frame boundaries, which prevents tearing.
- Sits between the host register/logic that produces display values and the board anode/cathode pins.

---
 rtl/seg7_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Time-slices the cathode bus across four anodes. Applies per-digit blanking, decimal points
// and PWM brightness. Host writes land in a shadow set that commits only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  input  logic [3:0]  brightness,
  input  logic        disp_en,
  output logic [3:0]  anodeON,
  output logic [6:0]  cathodeOFF,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] SlotLast = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       pwm_q;

  logic [15:0] act_val_q, sh_val_q;
  logic [3:0]  act_dp_q, sh_dp_q;
  logic [3:0]  act_blank_q, sh_blank_q;
  logic        pending_q;
  logic        frame_tick_q;

  logic [3:0]  anode_q, anode_d;
  logic [6:0]  cath_q, seg_d;
  logic        dp_n_q;

  logic        slot_tick;
  logic        frame_bnd;
  logic [3:0]  cur_nib;

  // Slot/frame timing, anode gating and hex decode of the digit being scanned
  always_comb begin
    slot_tick  = (slot_cnt_q == SlotLast);
    frame_bnd  = slot_tick && (idx_q == 2'd3);
    slot_cnt_d = slot_tick ? '0 : slot_cnt_q + CNT_W'(1);
    idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;
    cur_nib    = act_val_q[{idx_q, 2'b00} +: 4];

    // Dark on the slot-tick computation so the next slot opens with anodes off (ghost guard)
    anode_d = 4'b0000;
    if (!slot_tick && disp_en && !act_blank_q[idx_q] && (pwm_q <= brightness)) begin
      anode_d = 4'b0001 << idx_q;
    end

    seg_d = 7'h7F;
    unique case (cur_nib)
      4'h0: seg_d = 7'h40;
      4'h1: seg_d = 7'h79;
      4'h2: seg_d = 7'h24;
      4'h3: seg_d = 7'h30;
      4'h4: seg_d = 7'h19;
      4'h5: seg_d = 7'h12;
      4'h6: seg_d = 7'h02;
      4'h7: seg_d = 7'h78;
      4'h8: seg_d = 7'h00;
      4'h9: seg_d = 7'h10;
      4'hA: seg_d = 7'h08;
      4'hB: seg_d = 7'h03;
      4'hC: seg_d = 7'h46;
      4'hD: seg_d = 7'h21;
      4'hE: seg_d = 7'h06;
      4'hF: seg_d = 7'h0E;
      default: seg_d = 7'h7F;
    endcase
  end

  // Free-running slot counter, digit index and PWM counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q      <= 2'd0;
      pwm_q      <= 4'd0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_q + 4'd1;
    end
  end

  // Shadow capture and frame-boundary commit; a load on the boundary stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val_q   <= 16'h0000;
      act_dp_q    <= 4'b0000;
      act_blank_q <= 4'b1111;
      sh_val_q    <= 16'h0000;
      sh_dp_q     <= 4'b0000;
      sh_blank_q  <= 4'b1111;
      pending_q   <= 1'b0;
    end else begin
      if (frame_bnd && pending_q) begin
        act_val_q   <= sh_val_q;
        act_dp_q    <= sh_dp_q;
        act_blank_q <= sh_blank_q;
      end
      if (load) begin
        sh_val_q   <= value_in;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank_in;
        pending_q  <= 1'b1;
      end else if (frame_bnd) begin
        pending_q  <= 1'b0;
      end
    end
  end

  // Registered pin drive from the current index and active set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q      <= 4'b0000;
      cath_q       <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      anode_q      <= anode_d;
      cath_q       <= seg_d;
      dp_n_q       <= ~act_dp_q[idx_q];
      frame_tick_q <= frame_bnd;
    end
  end

  assign anodeON    = anode_q;
  assign cathodeOFF = cath_q;
  assign dp_n       = dp_n_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-indexed reference model pushes the expected pin
// state at every rising edge; a checker pops and compares it just after that edge.
module tb_seg7_scan_ctrl;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Frame  = 4 * ClkDiv;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [3:0]  brightness;
  logic        disp_en;
  logic [3:0]  anodeON;
  logic [6:0]  cathodeOFF;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;

  seg7_scan_ctrl #(
    .CLK_DIV(ClkDiv),
    .CNT_W  (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .load      (load),
    .brightness(brightness),
    .disp_en   (disp_en),
    .anodeON   (anodeON),
    .cathodeOFF(cathodeOFF),
    .dp_n      (dp_n),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] cat;
    logic       dpn;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Reference model: m_t counts clocks since reset release; slot, index and pwm derive from it.
  int unsigned m_t;
  logic [15:0] m_val, m_sval;
  logic [3:0]  m_dp, m_sdp, m_blank, m_sblank;
  logic        m_pend;

  initial begin
    exp_t e;
    int unsigned pos, idx, pwm;
    logic tick, bnd;
    m_t = 0; m_val = '0; m_sval = '0; m_dp = '0; m_sdp = '0;
    m_blank = 4'hF; m_sblank = 4'hF; m_pend = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t = 0; m_val = '0; m_sval = '0; m_dp = '0; m_sdp = '0;
        m_blank = 4'hF; m_sblank = 4'hF; m_pend = 1'b0;
        e = '{an: 4'h0, cat: 7'h7F, dpn: 1'b1, pend: 1'b0, ft: 1'b0};
      end else begin
        pos  = m_t % ClkDiv;
        idx  = (m_t / ClkDiv) % 4;
        pwm  = m_t % 16;
        tick = (pos == ClkDiv - 1);
        bnd  = tick && (idx == 3);
        e.an = 4'h0;
        if (!tick && disp_en && !m_blank[idx] && (pwm <= brightness)) e.an = 4'(1 << idx);
        e.cat = seg_of(4'(m_val >> (4 * idx)));
        e.dpn = !m_dp[idx];
        e.ft  = bnd;
        if (bnd && m_pend) begin
          m_val = m_sval; m_dp = m_sdp; m_blank = m_sblank;
        end
        if (load) begin
          m_sval = value_in; m_sdp = dp_in; m_sblank = blank_in; m_pend = 1'b1;
        end else if (bnd) begin
          m_pend = 1'b0;
        end
        e.pend = m_pend;
        m_t++;
      end
      exp_q.push_back(e);
    end
  end

  // Scoreboard checker
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("anodeON", 16'(anodeON), 16'(e.an));
        check("cathodeOFF", 16'(cathodeOFF), 16'(e.cat));
        check("dp_n", 16'(dp_n), 16'(e.dpn));
        check("pending", 16'(pending), 16'(e.pend));
        check("frame_tick", 16'(frame_tick), 16'(e.ft));
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    value_in = v; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_anode"}, 16'(anodeON), 16'h0);
    check({tag, "_cath"}, 16'(cathodeOFF), 16'h7F);
    check({tag, "_dpn"}, 16'(dp_n), 16'h1);
    check({tag, "_pend"}, 16'(pending), 16'h0);
    check({tag, "_ft"}, 16'(frame_tick), 16'h0);
  endtask

  initial begin
    logic found;
    rst = 1'b1; value_in = '0; dp_in = '0; blank_in = '0; load = 1'b0;
    brightness = 4'd15; disp_en = 1'b1;
    #1;
    check_reset_pins("rst0");
    run(3);
    rst = 1'b0;

    // Idle after reset: dark, frame ticks every 16 clocks
    run(32);

    // Mid-frame load; commits at the next boundary
    run(5);
    do_load(16'h1234, 4'b0100, 4'b0000);
    run(40);

    // Two loads within one frame: only the last is ever shown
    run(3);
    do_load(16'h00AF, 4'b0000, 4'b0000);
    run(2);
    do_load(16'hBEEF, 4'b0011, 4'b0000);
    run(40);

    // Load on the exact boundary cycle while the shadow holds 1111
    do_load(16'h1111, 4'b0000, 4'b0000);
    found = 1'b0;
    for (int i = 0; i < 2 * Frame; i++) begin
      if ((m_t % Frame) == Frame - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bnd_found", 16'(found), 16'h1);
    value_in = 16'hFFFF; dp_in = 4'b1001; blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    run(40);

    // Blanking, reduced brightness, display disable
    do_load(16'h5678, 4'b1111, 4'b1010);
    run(36);
    brightness = 4'd3;
    run(48);
    brightness = 4'd8;
    run(32);
    disp_en = 1'b0;
    run(24);
    disp_en = 1'b1;
    brightness = 4'd15;

    // A few random loads
    for (int i = 0; i < 4; i++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
      run(int'($urandom_range(3, 24)));
    end
    run(20);

    // Async reset mid-slot with a pending shadow
    do_load(16'h9ABC, 4'b0000, 4'b0000);
    check("pend_before_rst", 16'(pending), 16'h1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_pins("rst_mid");
    run(3);
    rst = 1'b0;
    run(40);

    run(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
